// File: rtl/sub4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub4_pkg
// Brief    : Shared types, widths and saturating-add helper for sub4_accum.
// Revision : 1.0
// ============================================================================
package sub4_pkg;

    localparam int RES_W = 5;
    localparam int SUM_W = RES_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Adds at full 32-bit precision, then clamps into a signed 'width'-bit range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] acc,
        input logic signed [31:0] delta,
        input int                 width
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r  = acc + delta;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub4_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sub4_sat_add
// Brief    : 6-bit sample-pair sum folded into a saturating ACC_W accumulator.
// Revision : 1.0
// ============================================================================
module sub4_sat_add
    import sub4_pkg::*;
#(
    parameter int ACC_W = 9
) (
    input  logic        [RES_W-1:0] s1,
    input  logic        [RES_W-1:0] s2,
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [SUM_W-1:0] w_delta;
    logic signed [31:0]      w_acc32;
    logic signed [31:0]      w_delta32;
    logic signed [31:0]      w_raw32;
    logic signed [31:0]      w_sat32;

    assign w_delta   = $signed({s1[RES_W-1], s1}) + $signed({s2[RES_W-1], s2});
    assign w_acc32   = {{(32 - ACC_W){acc[ACC_W-1]}}, acc};
    assign w_delta32 = {{(32 - SUM_W){w_delta[SUM_W-1]}}, w_delta};
    assign w_raw32   = w_acc32 + w_delta32;
    assign w_sat32   = sat_add(w_acc32, w_delta32, ACC_W);

    // Any difference between clamped and exact sums means a clamp happened.
    assign ovf = (w_sat32 != w_raw32);
    assign sum = w_sat32[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/sub4_accum.sv
`default_nettype none
// ============================================================================
// Module   : sub4_accum
// Brief    : Windowed saturating accumulator of subtractor result pairs with a
//            valid/ready hold stage for the window total.
// Revision : 1.0
// ============================================================================
module sub4_accum
    import sub4_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic        [RES_W-1:0] s1,
    input  logic        [RES_W-1:0] s2,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] acc_out,
    output logic        [7:0]       neg_cnt,
    output logic                    sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [7:0] c_n_samples = 8'(N_SAMPLES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_acc;
    logic        [7:0]       r_cnt;
    logic        [7:0]       r_neg;
    logic                    r_sat;

    logic                    w_accept;
    logic                    w_flush;
    logic        [7:0]       w_cnt_inc;
    logic        [7:0]       w_neg_inc;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;

    sub4_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .s1  (s1),
        .s2  (s2),
        .acc (r_acc),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_neg_inc = {7'd0, s1[RES_W-1]} + {7'd0, s2[RES_W-1]};

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = (w_cnt_inc == c_n_samples) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_flush     = 1'b1;
            end
        endcase
        // Abort wins over any accept or handshake in the same cycle.
        if (clear) begin
            w_state_nxt = IDLE;
            w_flush     = 1'b1;
        end
    end

    // in_ready/out_valid are registered from the next state, never from in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != HOLD);
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_neg <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_neg <= r_neg + w_neg_inc;
            r_sat <= r_sat | w_ovf;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign neg_cnt   = r_neg;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_sub4_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub4_accum
// Brief    : Three sub4_accum configurations against an integer window model.
// Revision : 1.0
// ============================================================================
module tb_sub4_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [4:0] s1_i        [3];
    logic [4:0] s2_i        [3];
    logic       in_valid_i  [3];
    logic       clear_i     [3];
    logic       out_ready_i [3];
    logic       in_ready_o  [3];
    logic       out_valid_o [3];
    logic       sat_o       [3];
    logic [7:0] neg_o       [3];
    logic signed [8:0] acc_a;
    logic signed [5:0] acc_b;
    logic signed [8:0] acc_c;
    int         got_acc     [3];

    always_comb begin
        got_acc[0] = int'(acc_a);
        got_acc[1] = int'(acc_b);
        got_acc[2] = int'(acc_c);
    end

    sub4_accum #(.N_SAMPLES(8), .ACC_W(9)) u_a (
        .clk(clk), .rst_n(rst_n), .s1(s1_i[0]), .s2(s2_i[0]),
        .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]), .clear(clear_i[0]),
        .acc_out(acc_a), .neg_cnt(neg_o[0]), .sat(sat_o[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready_i[0])
    );
    sub4_accum #(.N_SAMPLES(8), .ACC_W(6)) u_b (
        .clk(clk), .rst_n(rst_n), .s1(s1_i[1]), .s2(s2_i[1]),
        .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]), .clear(clear_i[1]),
        .acc_out(acc_b), .neg_cnt(neg_o[1]), .sat(sat_o[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready_i[1])
    );
    sub4_accum #(.N_SAMPLES(1), .ACC_W(9)) u_c (
        .clk(clk), .rst_n(rst_n), .s1(s1_i[2]), .s2(s2_i[2]),
        .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]), .clear(clear_i[2]),
        .acc_out(acc_c), .neg_cnt(neg_o[2]), .sat(sat_o[2]),
        .out_valid(out_valid_o[2]), .out_ready(out_ready_i[2])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window model: integer running sum clamped to the configured range.
    int c_n [3] = '{8, 8, 1};
    int c_w [3] = '{9, 6, 9};
    int m_sum [3];
    int m_cnt [3];
    int m_neg [3];
    int m_sat [3];
    int m_hold [3];
    int m_v, m_hi, m_lo;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || clear_i[k] || (m_hold[k] != 0 && out_ready_i[k])) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_neg[k] = 0; m_sat[k] = 0; m_hold[k] = 0;
            end else if (m_hold[k] == 0 && in_valid_i[k]) begin
                m_hi = (1 << (c_w[k] - 1)) - 1;
                m_lo = -(1 << (c_w[k] - 1));
                m_v  = m_sum[k] + int'($signed(s1_i[k])) + int'($signed(s2_i[k]));
                if (m_v > m_hi) begin m_v = m_hi; m_sat[k] = 1; end
                if (m_v < m_lo) begin m_v = m_lo; m_sat[k] = 1; end
                m_sum[k] = m_v;
                m_neg[k] = m_neg[k] + int'(s1_i[k][4]) + int'(s2_i[k][4]);
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == c_n[k]) m_hold[k] = 1;
            end
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("in_ready[%0d]", k),  int'(in_ready_o[k]),  (m_hold[k] != 0) ? 0 : 1);
                chk($sformatf("out_valid[%0d]", k), int'(out_valid_o[k]), (m_hold[k] != 0) ? 1 : 0);
                chk($sformatf("acc_out[%0d]", k),   got_acc[k],           m_sum[k]);
                chk($sformatf("neg_cnt[%0d]", k),   int'(neg_o[k]),       m_neg[k]);
                chk($sformatf("sat[%0d]", k),       int'(sat_o[k]),       m_sat[k]);
            end
        end
    end

    function automatic logic [4:0] to5(input int v);
        return v[4:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        for (int k = 0; k < 3; k++) begin
            s1_i[k] = '0; s2_i[k] = '0;
            in_valid_i[k] = 1'b0; clear_i[k] = 1'b0; out_ready_i[k] = 1'b0;
        end
    endtask

    task automatic send(input int k, input int a, input int b, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid_i[k] = 1'b1; s1_i[k] = to5(a); s2_i[k] = to5(b);
            step();
        end
        in_valid_i[k] = 1'b0;
    endtask

    task automatic release_out(input int k);
        out_ready_i[k] = 1'b1;
        step();
        out_ready_i[k] = 1'b0;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        step(); step();
        chk("rst in_ready",  int'(in_ready_o[0]),  1);
        chk("rst out_valid", int'(out_valid_o[0]), 0);
        chk("rst acc_out",   got_acc[0],           0);
        chk("rst neg_cnt",   int'(neg_o[0]),       0);
        chk("rst sat",       int'(sat_o[0]),       0);
        rst_n = 1'b1;

        // Eight (3,-4) samples: latency and totals.
        send(0, 3, -4, 7);
        chk("t1 valid after 7", int'(out_valid_o[0]), 0);
        send(0, 3, -4, 1);
        chk("t1 valid after 8", int'(out_valid_o[0]), 1);
        chk("t1 acc",           got_acc[0],           -8);
        chk("t1 neg",           int'(neg_o[0]),       8);
        chk("t1 sat",           int'(sat_o[0]),       0);

        // Held result ignores toggling in_valid.
        for (int i = 0; i < 5; i++) begin
            in_valid_i[0] = i[0]; s1_i[0] = to5(5); s2_i[0] = to5(-7);
            step();
            chk("hold acc",      got_acc[0],          -8);
            chk("hold in_ready", int'(in_ready_o[0]), 0);
        end
        in_valid_i[0] = 1'b0;
        release_out(0);
        chk("t1 released acc", got_acc[0],           0);
        chk("t1 released rdy", int'(in_ready_o[0]),  1);

        // Saturation with a 6-bit accumulator.
        send(1, 15, 15, 8);
        chk("t2 pos acc", got_acc[1],      31);
        chk("t2 pos sat", int'(sat_o[1]),  1);
        release_out(1);
        send(1, -16, -16, 8);
        chk("t2 neg acc", got_acc[1],      -32);
        chk("t2 neg sat", int'(sat_o[1]),  1);
        chk("t2 neg cnt", int'(neg_o[1]),  16);
        release_out(1);

        // clear mid-window together with a sample.
        send(0, 2, 1, 4);
        clear_i[0] = 1'b1; in_valid_i[0] = 1'b1; s1_i[0] = to5(7); s2_i[0] = to5(7);
        step();
        clear_i[0] = 1'b0; in_valid_i[0] = 1'b0;
        chk("t3 clr acc",   got_acc[0],           0);
        chk("t3 clr neg",   int'(neg_o[0]),       0);
        chk("t3 clr valid", int'(out_valid_o[0]), 0);
        send(0, 2, -1, 7);
        chk("t3 valid after 7", int'(out_valid_o[0]), 0);
        send(0, 2, -1, 1);
        chk("t3 valid after 8", int'(out_valid_o[0]), 1);
        chk("t3 acc",           got_acc[0],           8);
        chk("t3 neg",           int'(neg_o[0]),       8);

        // Reset in HOLD coinciding with out_ready.
        rst_n = 1'b0; out_ready_i[0] = 1'b1;
        step();
        rst_n = 1'b1; out_ready_i[0] = 1'b0;
        chk("t4 acc",   got_acc[0],           0);
        chk("t4 valid", int'(out_valid_o[0]), 0);
        chk("t4 rdy",   int'(in_ready_o[0]),  1);
        step();
        chk("t4 no window", int'(out_valid_o[0]), 0);

        // Single-sample window.
        send(2, -1, 2, 1);
        chk("t5 valid", int'(out_valid_o[2]), 1);
        chk("t5 acc",   got_acc[2],           1);
        chk("t5 neg",   int'(neg_o[2]),       1);
        release_out(2);

        // Randomized traffic on all three configurations.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid_i[k]  = ($urandom_range(0, 3) != 0);
                s1_i[k]        = 5'($urandom);
                s2_i[k]        = 5'($urandom);
                clear_i[k]     = ($urandom_range(0, 39) == 0);
                out_ready_i[k] = ($urandom_range(0, 2) == 0);
            end
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        quiet();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
